// File: rtl/tmds_decoder.sv
// Receive-side TMDS channel: aligns the serial stream on control tokens, then
// classifies each 10-bit word as video, control or guard and decodes video bytes.
module tmds_decoder #(
    parameter int         LOCK_COUNT = 4,
    parameter int         MAX_GAP    = 4096,
    parameter logic [9:0] GUARD_WORD = 10'b1011001100
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       s_rst,
    input  logic       serial_in,
    output logic [7:0] data_out,
    output logic [1:0] ctrl_out,
    output logic [1:0] word_type,
    output logic [9:0] raw_word,
    output logic       word_valid,
    output logic       locked,
    output logic       sync_err
);
    localparam int MW = $clog2(LOCK_COUNT + 1);
    localparam int GW = $clog2(MAX_GAP + 1) + 1;
    localparam logic [MW-1:0] MATCH_LOCK = MW'(LOCK_COUNT);
    localparam logic [GW-1:0] GAP_LIMIT  = GW'(MAX_GAP);

    typedef enum logic [1:0] {S_HUNT, S_VERIFY, S_LOCKED} state_t;

    state_t        state_q, state_d;
    logic [9:0]    sr_q, sr_d;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [MW-1:0] match_q, match_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [7:0]    data_q, data_d;
    logic [1:0]    ctrl_q, ctrl_d;
    logic [1:0]    type_q, type_d;
    logic [9:0]    raw_q, raw_d;
    logic          valid_q, valid_d;
    logic          err_q, err_d;
    logic [2:0]    tok;
    logic          boundary;

    // Returns {hit, C1, C0}
    function automatic logic [2:0] token_lookup(input logic [9:0] w);
        case (w)
            10'b1101010100: token_lookup = 3'b100;
            10'b0010101011: token_lookup = 3'b101;
            10'b0101010100: token_lookup = 3'b110;
            10'b1010101011: token_lookup = 3'b111;
            default:        token_lookup = 3'b000;
        endcase
    endfunction

    function automatic logic [7:0] video_decode(input logic [9:0] w);
        logic [7:0] q;
        logic [7:0] d;
        q    = w[9] ? ~w[7:0] : w[7:0];
        d    = '0;
        d[0] = q[0];
        for (int i = 1; i < 8; i++) begin
            d[i] = w[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
        end
        return d;
    endfunction

    assign tok      = token_lookup(sr_q);
    assign boundary = (bit_cnt_q == 4'd9);

    always_comb begin
        state_d   = state_q;
        sr_d      = {serial_in, sr_q[9:1]};
        bit_cnt_d = boundary ? 4'd0 : bit_cnt_q + 4'd1;
        match_d   = match_q;
        gap_d     = gap_q;
        data_d    = data_q;
        ctrl_d    = ctrl_q;
        type_d    = type_q;
        raw_d     = raw_q;
        valid_d   = 1'b0;
        err_d     = 1'b0;

        case (state_q)
            S_HUNT: begin
                if (tok[2]) begin
                    bit_cnt_d = 4'd0;
                    match_d   = MW'(1);
                    if (MATCH_LOCK <= MW'(1)) begin
                        state_d = S_LOCKED;
                        gap_d   = '0;
                    end else begin
                        state_d = S_VERIFY;
                    end
                end
            end
            S_VERIFY: begin
                if (boundary) begin
                    if (!tok[2]) begin
                        state_d = S_HUNT;
                    end else begin
                        match_d = match_q + MW'(1);
                        if (match_q + MW'(1) == MATCH_LOCK) begin
                            state_d = S_LOCKED;
                            gap_d   = '0;
                        end
                    end
                end
            end
            S_LOCKED: begin
                if (boundary) begin
                    if (tok[2]) begin
                        valid_d = 1'b1;
                        raw_d   = sr_q;
                        type_d  = 2'b01;
                        ctrl_d  = tok[1:0];
                        gap_d   = '0;
                    end else if (gap_q == GAP_LIMIT) begin
                        // Too long without a token: alignment is no longer trusted
                        err_d   = 1'b1;
                        state_d = S_HUNT;
                    end else begin
                        valid_d = 1'b1;
                        raw_d   = sr_q;
                        gap_d   = gap_q + GW'(1);
                        if (sr_q == GUARD_WORD) begin
                            type_d = 2'b10;
                        end else begin
                            type_d = 2'b00;
                            data_d = video_decode(sr_q);
                        end
                    end
                end
            end
            default: state_d = S_HUNT;
        endcase

        if (s_rst) begin
            state_d   = S_HUNT;
            sr_d      = '0;
            bit_cnt_d = '0;
            match_d   = '0;
            gap_d     = '0;
            data_d    = '0;
            ctrl_d    = '0;
            type_d    = '0;
            raw_d     = '0;
            valid_d   = 1'b0;
            err_d     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q   <= S_HUNT;
            sr_q      <= '0;
            bit_cnt_q <= '0;
            match_q   <= '0;
            gap_q     <= '0;
            data_q    <= '0;
            ctrl_q    <= '0;
            type_q    <= '0;
            raw_q     <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            bit_cnt_q <= bit_cnt_d;
            match_q   <= match_d;
            gap_q     <= gap_d;
            data_q    <= data_d;
            ctrl_q    <= ctrl_d;
            type_q    <= type_d;
            raw_q     <= raw_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
        end
    end

    assign data_out   = data_q;
    assign ctrl_out   = ctrl_q;
    assign word_type  = type_q;
    assign raw_word   = raw_q;
    assign word_valid = valid_q;
    assign sync_err   = err_q;
    assign locked     = (state_q == S_LOCKED);

endmodule

// File: doc/tmds_decoder.md
Name: tmds_decoder

Overview:
Receive-side counterpart of the TMDS transmit channel. It takes one TMDS channel's serial bitstream, one bit per clk, and finds 10-bit word boundaries by hunting for control tokens. It then classifies each word as video, control or guard, and decodes video words back to 8-bit pixel data. It is used in the loopback and verification path, one instance per channel.

Parameters:
LOCK_COUNT, 4, consecutive boundary-aligned control tokens required to declare lock
MAX_GAP, 4096, words allowed without any control token while locked before lock is dropped
GUARD_WORD, 10'b1011001100, video guard-band code for this channel (10'b0100110011 for channel 1)

Ports:
clk  input  1  bit clock; one serial bit sampled per rising edge
n_rst  input  1  asynchronous active-low reset
s_rst  input  1  synchronous reset; same effect as n_rst, applied on the next edge
serial_in  input  1  TMDS serial bit; word bit 0 arrives first
data_out  output  8  decoded pixel byte; valid when word_type=00
ctrl_out  output  2  decoded {C1,C0}; valid when word_type=01
word_type  output  2  00 video, 01 control, 10 guard, 11 unused
raw_word  output  10  aligned 10-bit word before decoding
word_valid  output  1  one-cycle pulse per decoded word
locked  output  1  high in LOCKED state
sync_err  output  1  one-cycle pulse when lock is lost

Behaviour:
- Reset (n_rst low, or s_rst high at an edge):
  - All outputs go to 0.
  - Shift register sr and bit_cnt go to 0.
  - Match and gap counters go to 0.
  - State goes to HUNT.
- Shift register: each edge, sr <= {serial_in, sr[9:1]}. After 10 shifts, sr[0] holds word bit 0.
- Control tokens, by sr[9:0]:
  - 1101010100 -> 00
  - 0010101011 -> 01
  - 0101010100 -> 10
  - 1010101011 -> 11
- bit_cnt (4 bits) counts 0..9 and wraps. A boundary is the cycle in which bit_cnt==9.
- HUNT:
  - Checks sr against the control tokens every cycle.
  - On a match: bit_cnt <= 0, match count <= 1, go to VERIFY.
  - No outputs are produced in HUNT.
- VERIFY, at each boundary:
  - If sr is a control token, match count increments. When it reaches LOCK_COUNT, go to LOCKED and clear the gap counter.
  - If sr is not a control token, return to HUNT immediately with no sync_err.
- LOCKED, at each boundary:
  - Register raw_word <= sr and pulse word_valid on the next edge.
  - Classify with priority control token > GUARD_WORD > video.
  - Control: word_type=01, ctrl_out=token value, data_out holds its previous value, gap counter cleared.
  - Guard: word_type=10, data_out and ctrl_out hold.
  - Video: word_type=00 and data_out is decoded:
    - q = sr[9] ? ~sr[7:0] : sr[7:0]
    - data_out[0] = q[0]
    - data_out[i] = sr[8] ? q[i]^q[i-1] : ~(q[i]^q[i-1]), for i=1..7
    - ctrl_out holds.
  - Every non-control word increments the gap counter.
  - If the gap counter would exceed MAX_GAP: pulse sync_err, drop locked, go to HUNT, and emit no word_valid for that word.
- Latency: last bit of a word sampled at edge E; word_valid, raw_word and decoded fields appear after edge E+1 and stay stable until the next word.
- word_valid is never high on two consecutive cycles. In LOCKED it pulses exactly once every 10 cycles.
- Entering LOCKED: the word that completes lock is not emitted. word_valid first pulses at the following boundary.
- A control token seen mid-word while LOCKED is ignored; no realignment occurs without first returning to HUNT.
- s_rst asserted in the same cycle as a boundary: reset wins and no word_valid is produced.
- Async reset mid-word: all outputs clear immediately; the next word's alignment restarts from HUNT.

Test Plan:
1. Lock from arbitrary phase: 3 random bits, then 6× token 1101010100 -> locked rises after the 4th token's boundary plus 1 edge; the 5th and 6th tokens give word_valid with word_type=01, ctrl_out=00, and word_valid pulses exactly every 10 clks.
2. Video decode after lock:
   - raw 0100000000 -> data_out=0x00
   - raw 0011111111 -> 0xFF
   - raw 1011111111 -> 0xFE
   - each with word_type=00 and raw_word echoed.
3. Guard and other tokens: GUARD_WORD -> word_type=10 with data_out holding the prior value; 0010101011 -> ctrl_out=01; 1010101011 -> ctrl_out=11.
4. Failed verify: 2 control tokens followed by video word 0100000000 -> back to HUNT; locked stays 0, no word_valid, no sync_err.
5. Loss of lock: MAX_GAP overridden to 8; lock, then 9 video words -> sync_err pulses once at the 9th word's boundary, locked=0, and only 8 word_valid pulses are seen.
6. Resets: n_rst pulsed mid-word while LOCKED -> all outputs 0 immediately and relock requires LOCK_COUNT new tokens; s_rst asserted on a boundary cycle -> no word_valid, state HUNT.
